set_job_fifo: RTL
=================

Name: set_job_fifo

Overview:
- Parametrised successor to the single-entry SET input holding register: a DEPTH-entry FIFO of SET job descriptors (central, radius, mode).
- Uses a valid/ready handshake on both sides.
- Sits between the host input interface and the SET compute core, so new jobs can be accepted while the core is still busy.
- Adds a synchronous flush, an occupancy count and a sticky drop flag.

Parameters:
- CENTRAL_W, 24, width of the central-coordinate field
- RADIUS_W, 12, width of the radius field
- MODE_W, 2, width of the mode field
- DEPTH, 4, number of entries; power of two, at least 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous flush; empties the FIFO and clears drop_o
- in_valid_i  in  1  upstream presents a job
- in_ready_o  out  1  FIFO can accept a job; equals !full
- central_i  in  CENTRAL_W  job central coordinates
- r_i  in  RADIUS_W  job radii
- mode_i  in  MODE_W  job mode
- out_valid_o  out  1  head entry valid; equals !empty
- out_ready_i  in  1  core consumes the head entry
- central_o  out  CENTRAL_W  head central value; 0 when empty
- r_o  out  RADIUS_W  head radius value; 0 when empty
- mode_o  out  MODE_W  head mode value; 0 when empty
- count_o  out  CNT_W  current occupancy, 0..DEPTH
- drop_o  out  1  sticky flag; set when in_valid_i=1 while in_ready_o=0

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - pointers=0, count_o=0, drop_o=0
  - out_valid_o=0, in_ready_o=1
  - data outputs=0
  - storage array contents are don't-care
- Push: in_valid_i & in_ready_o at a rising edge writes {central_i, r_i, mode_i} at the write pointer; the write pointer increments.
- Pop: out_valid_o & out_ready_i at a rising edge advances the read pointer.
- Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Full/empty is derived from count_o, never from pointer equality alone.
- Latency: a job pushed into an empty FIFO shows out_valid_o=1 with its data on the next cycle. No combinational in->out bypass.
- Outputs:
  - Data outputs are driven combinationally from the head entry, masked to 0 when empty.
  - in_ready_o and out_valid_o depend only on registered count, never on in_valid_i or out_ready_i.
- Simultaneous push and pop:
  - Not full, not empty: both occur; count unchanged.
  - Empty: only the push occurs (out_valid_o=0); count goes 0 -> 1.
  - Full: only the pop occurs (in_ready_o=0); count goes DEPTH -> DEPTH-1. The rejected push sets drop_o.
- Upstream must hold in_valid_i and data stable until accepted. The FIFO never reorders or duplicates.
- drop_o:
  - Set on any cycle with in_valid_i=1 and in_ready_o=0.
  - Stays set until clear_i or reset.
  - Diagnostic only; does not affect data flow.
- clear_i (synchronous, highest priority after reset):
  - Next edge: pointers=0, count_o=0, drop_o=0.
  - A same-cycle push and pop are discarded.
  - in_ready_o=1 and out_valid_o=0 on the following cycle.
- Reset mid-operation: all in-flight entries are lost. Outputs reach reset values immediately on rst_ni falling, without waiting for a clock edge.
- count_o: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then push A=(central 24'h123456, r 12'h345, mode 2'd1) with out_ready_i=0 -> next cycle out_valid_o=1, central_o=24'h123456, r_o=12'h345, mode_o=1, count_o=1.
- DEPTH=4: push 4 jobs with out_ready_i=0 -> count_o=4, in_ready_o=0. Assert in_valid_i one more cycle -> drop_o=1, count stays 4, head still job 0.
- FIFO full: assert in_valid_i and out_ready_i together -> pop only; count_o=3 next cycle, drop_o set. Drain -> jobs emerge in order 0,1,2,3, then out_valid_o=0 and data outputs 0.
- Steady streaming: push and pop every cycle for 10 jobs, starting from count 1 -> count_o stays 1, pointers wrap twice, output sequence equals input sequence.
- FIFO at count 2 with drop_o=1: pulse clear_i together with a push -> next cycle count_o=0, out_valid_o=0, drop_o=0; the pushed job is not stored.
- FIFO at count 3: drive rst_ni low between clock edges -> out_valid_o=0, count_o=0 and data outputs 0 before the next edge. After release, the first push appears as the head.

Source files
------------

// File: rtl/set_job_fifo.sv
// DEPTH-entry FIFO of SET job descriptors (central, radius, mode) between the
// host input interface and the SET compute core, with flush, occupancy and drop flag.
module set_job_fifo #(
    parameter int CENTRAL_W = 24,
    parameter int RADIUS_W  = 12,
    parameter int MODE_W    = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CENTRAL_W-1:0] central_i,
    input  logic [RADIUS_W-1:0]  r_i,
    input  logic [MODE_W-1:0]    mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CENTRAL_W-1:0] central_o,
    output logic [RADIUS_W-1:0]  r_o,
    output logic [MODE_W-1:0]    mode_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 drop_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } job_t;

    job_t             mem_q [DEPTH];
    job_t             in_job;
    job_t             head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Full/empty come from the registered count only, so the handshake
    // outputs never depend combinationally on in_valid_i or out_ready_i.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid_i & ~full;
    assign pop   = out_ready_i & ~empty;

    assign in_job = '{central: central_i, radius: r_i, mode: mode_i};

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (in_valid_i && full) drop_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty masking hides stale entries.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem_q[wr_ptr_q] <= in_job;
    end

    assign head = mem_q[rd_ptr_q];

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign central_o   = empty ? '0 : head.central;
    assign r_o         = empty ? '0 : head.radius;
    assign mode_o      = empty ? '0 : head.mode;
    assign count_o     = count_q;
    assign drop_o      = drop_q;

endmodule
